slow_clk_monitor: RTL and testbench
===================================

// Module: slow_clk_monitor
// PURPOSE
//  Fast-domain consumer of the divided slow clock (counter-MSB square wave).
//  Synchronises slowClk into clk100Mhz, emits a 1-cycle tick per rising edge,
//  measures the slowClk period in fast cycles, and flags a stalled divider.
//  Downstream logic uses tick as a clock enable; slowClk never clocks flops.
// PARAMETERS
//  SYNC_STAGES  2        synchroniser depth (>=2)
//  CNT_W        30       width of period counter / period output
//  TIMEOUT      2**29    fast cycles without a rise before stall (< 2**CNT_W)
// PORTS
//  clk100Mhz     in   1      fast system clock, all logic on posedge
//  resetn        in   1      synchronous reset, active-low
//  slowClk       in   1      asynchronous slow square wave
//  tick          out  1      1-cycle pulse per detected slowClk rise
//  period        out  CNT_W  last measured rise-to-rise period, fast cycles
//  period_valid  out  1      1-cycle pulse when period updates
//  timeout       out  1      level: no rise seen for TIMEOUT cycles
//  tick_count    out  8      free-running count of ticks, wraps 255->0
// BEHAVIOUR
//  Reset (resetn=0 at posedge): sync chain, edge reg, cnt, period, tick,
//   period_valid, timeout, tick_count all 0; state=WAIT_FIRST.
//   Reset overrides everything, including mid-measurement.
//  Sync: s[0]<=slowClk, s[i]<=s[i-1]; prev<=s[LAST]; rise=s[LAST]&~prev.
//  Latency: slowClk high before edge E0 -> tick high only in the cycle after
//   edge E0+SYNC_STAGES. High pulses shorter than 1 fast cycle may be missed.
//  tick<=rise; tick_count<=tick_count+1 on each rise (mod 256), in all states.
//  States:
//   WAIT_FIRST: cnt held 0. rise -> MEASURE, cnt<=0, no period_valid.
//   MEASURE: cnt<=cnt+1 per cycle.
//    rise -> period<=cnt+1, period_valid<=1, cnt<=0, stay.
//    no rise and cnt==TIMEOUT-1 -> STALLED, timeout<=1, period unchanged.
//   STALLED: cnt held. rise -> MEASURE, cnt<=0, timeout<=0, no period_valid.
//   Rise in the same cycle as cnt==TIMEOUT-1: rise wins (valid period=TIMEOUT).
//  Period semantics: cycles between consecutive rise detections; a
//   constant P-cycle square wave yields period==P from the 2nd rise on.
//  period_valid and tick coincide (same cycle) on measuring rises.
//  timeout is a level; it clears only on a rise or reset.
//  No other outputs change outside the events listed.
// TESTING (bench uses TIMEOUT=64, CNT_W=8, SYNC_STAGES=2)
//  1 Reset: hold resetn=0 with slowClk toggling -> all outputs 0; 1st rise
//    after release gives tick but no period_valid.
//  2 slowClk 10 high/10 low, 5 periods -> tick every 20 cycles, 2 edges after
//    input rise; period==20 with period_valid from 2nd rise; tick_count==5.
//  3 Stop slowClk low after lock -> timeout=1 exactly 64 cycles after last
//    tick; period still 20; restart -> timeout=0 at 1st tick, no
//    period_valid; 2nd tick gives period_valid with period==20.
//  4 Rise landing exactly 64 cycles after previous -> period==64, valid,
//    timeout stays 0.
//  5 300 rises -> tick_count==44 (wrap at 256).
//  6 resetn=0 for 1 cycle mid-period -> next cycle all outputs 0,
//    WAIT_FIRST; next rise gives tick only.

Source files
------------

// File: rtl/slow_clk_monitor.sv
// Fast-domain monitor for a divided slow clock: synchronises it, emits a tick per rise,
// measures the rise-to-rise period in fast cycles and flags a stalled divider.
module slow_clk_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 30,
    parameter int TIMEOUT     = 2**29
) (
    input  logic             clk100Mhz,
    input  logic             resetn,
    input  logic             slowClk,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic [7:0]       tick_count
);

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        STALLED    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_period;
    logic                   r_tick;
    logic                   r_period_valid;
    logic                   r_timeout;
    logic [7:0]             r_tick_count;
    state_t                 r_state;
    logic                   w_rise;

    // slowClk is asynchronous: only the last synchroniser stage is ever used as data
    always_ff @(posedge clk100Mhz) begin
        if (!resetn) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], slowClk};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

    always_ff @(posedge clk100Mhz) begin
        if (!resetn) begin
            r_state        <= WAIT_FIRST;
            r_cnt          <= '0;
            r_period       <= '0;
            r_tick         <= 1'b0;
            r_period_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_tick_count   <= 8'd0;
        end else begin
            r_tick         <= w_rise;
            r_period_valid <= 1'b0;
            if (w_rise) begin
                r_tick_count <= r_tick_count + 8'd1;
            end
            case (r_state)
                WAIT_FIRST: begin
                    r_cnt <= '0;
                    if (w_rise) begin
                        r_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    // a rise on the final count still yields a valid period of TIMEOUT
                    if (w_rise) begin
                        r_period       <= r_cnt + CNT_W'(1);
                        r_period_valid <= 1'b1;
                        r_cnt          <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= STALLED;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STALLED: begin
                    if (w_rise) begin
                        r_state   <= MEASURE;
                        r_cnt     <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                default: begin
                    r_state <= WAIT_FIRST;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign tick         = r_tick;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign timeout      = r_timeout;
    assign tick_count   = r_tick_count;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Bench for slow_clk_monitor: directed scenarios plus random square waves, compared
// every cycle against a timestamp-based model of ticks, periods and stalls.
module tb_slow_clk_monitor;

    localparam int SYNC = 2;
    localparam int CW   = 8;
    localparam int TO   = 64;

    logic          clk;
    logic          resetn;
    logic          slowClk;
    logic          tick;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          timeout;
    logic [7:0]    tick_count;

    slow_clk_monitor #(
        .SYNC_STAGES(SYNC),
        .CNT_W      (CW),
        .TIMEOUT    (TO)
    ) dut (
        .clk100Mhz   (clk),
        .resetn      (resetn),
        .slowClk     (slowClk),
        .tick        (tick),
        .period      (period),
        .period_valid(period_valid),
        .timeout     (timeout),
        .tick_count  (tick_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Model: a rise is seen SYNC edges after the input goes high; periods are
    // differences of rise timestamps, a stall is TO edges without a rise.
    bit dly[$];
    bit m_tick, m_pv, m_to, m_started, m_stalled;
    int m_period, m_ticks, m_last;

    initial begin
        bit rise;
        dly = '{1'b0, 1'b0, 1'b0};
        m_tick = 0; m_pv = 0; m_to = 0; m_started = 0; m_stalled = 0;
        m_period = 0; m_ticks = 0; m_last = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!resetn) begin
                dly = '{1'b0, 1'b0, 1'b0};
                m_tick = 0; m_pv = 0; m_to = 0; m_started = 0; m_stalled = 0;
                m_period = 0; m_ticks = 0;
            end else begin
                rise = dly[SYNC-1] && !dly[SYNC];
                dly.push_front(slowClk);
                void'(dly.pop_back());
                m_tick = rise;
                m_pv   = 0;
                if (rise) begin
                    m_ticks = (m_ticks + 1) % 256;
                    if (m_started && !m_stalled) begin
                        m_pv     = 1;
                        m_period = cyc - m_last;
                    end
                    m_started = 1;
                    m_stalled = 0;
                    m_to      = 0;
                    m_last    = cyc;
                end else if (m_started && !m_stalled && (cyc - m_last == TO)) begin
                    m_stalled = 1;
                    m_to      = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("tick", int'(tick), int'(m_tick));
                check("period", int'(period), m_period);
                check("period_valid", int'(period_valid), int'(m_pv));
                check("timeout", int'(timeout), int'(m_to));
                check("tick_count", int'(tick_count), m_ticks);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_tick"}, int'(tick), 0);
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_pv"}, int'(period_valid), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
        check({tag, "_tick_count"}, int'(tick_count), 0);
    endtask

    // One slowClk period; when exp_pv >= 0 the tick latency and the outputs at the tick are pinned.
    task automatic sq(input int h, input int l, input int exp_pv, input int exp_per, input int exp_to);
        slowClk = 1'b1;
        for (int i = 1; i <= h; i++) begin
            @(negedge clk);
            if (exp_pv >= 0 && i == SYNC) check("lit_tick_early", int'(tick), 0);
            if (exp_pv >= 0 && i == SYNC + 1) begin
                check("lit_tick_latency", int'(tick), 1);
                check("lit_pv_at_tick", int'(period_valid), exp_pv);
                if (exp_per >= 0) check("lit_period_at_tick", int'(period), exp_per);
                if (exp_to >= 0) check("lit_timeout_at_tick", int'(timeout), exp_to);
            end
        end
        slowClk = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn  = 1'b0;
        slowClk = 1'b0;

        // reset held while slowClk toggles
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            slowClk = ~slowClk;
            @(negedge clk);
            if (i == 9) check_zero("lit_reset");
        end
        slowClk = 1'b0;
        resetn  = 1'b1;
        repeat (5) @(negedge clk);
        $display("scenario reset: done at cyc=%0d", cyc);

        // first rise: tick only; then locked 20-cycle period
        sq(10, 10, 0, -1, 0);
        for (int i = 0; i < 4; i++) sq(10, 10, 1, 20, 0);
        check("lit_period20", int'(period), 20);
        check("lit_tick_count5", int'(tick_count), 5);
        $display("scenario square20: tick_count=%0d period=%0d", tick_count, period);

        // stall: last tick was 17 cycles ago
        repeat (TO - 17 - 1) @(negedge clk);
        check("lit_timeout_before", int'(timeout), 0);
        @(negedge clk);
        check("lit_timeout_at64", int'(timeout), 1);
        check("lit_period_kept", int'(period), 20);
        repeat (20) @(negedge clk);
        sq(10, 10, 0, -1, 0);
        sq(10, 10, 1, 20, 0);
        $display("scenario stall/restart: timeout=%0d period=%0d", timeout, period);

        // rise exactly TO cycles after the previous one
        sq(10, TO - 10, 1, 20, 0);
        sq(10, 10, 1, TO, 0);
        sq(10, 10, 1, 20, 0);
        $display("scenario boundary: period=%0d timeout=%0d", period, timeout);

        // 300 rises from reset wrap the tick counter
        pulse_reset();
        for (int i = 0; i < 300; i++) sq(2, 2, -1, -1, -1);
        check("lit_tick_count_wrap", int'(tick_count), 44);
        $display("scenario wrap: tick_count=%0d", tick_count);

        // one-cycle reset in the low phase of a locked wave
        sq(10, 10, -1, -1, -1);
        sq(10, 10, 1, 20, 0);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check_zero("lit_midreset");
        repeat (5) @(negedge clk);
        sq(10, 10, 0, -1, 0);
        $display("scenario mid-reset: tick_count=%0d", tick_count);

        // random square waves, some long enough to stall, occasional resets
        for (int i = 0; i < 150; i++) begin
            int h, l;
            if ($urandom_range(0, 19) == 0) pulse_reset();
            h = $urandom_range(1, 20);
            l = ($urandom_range(0, 4) == 0) ? $urandom_range(50, 90) : $urandom_range(1, 40);
            sq(h, l, -1, -1, -1);
        end
        $display("scenario random: cyc=%0d tick_count=%0d", cyc, tick_count);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
